// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative RV64M multiply/divide (radix-2 shift-add, restoring div)
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int DATA_WIDTH    = 64,
  parameter int WORD_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_flush,
  input  logic [CONTROL_WIDTH-1:0] i_op,
  input  logic [DATA_WIDTH-1:0]    i_src_1,
  input  logic [DATA_WIDTH-1:0]    i_src_2,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [DATA_WIDTH-1:0]    o_result
);

  localparam int c_DW = DATA_WIDTH;
  localparam int c_WW = WORD_WIDTH;
  localparam int c_CW = $clog2(DATA_WIDTH);

  localparam logic [CONTROL_WIDTH-1:0] c_OP_MUL    = CONTROL_WIDTH'(0);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_MULH   = CONTROL_WIDTH'(1);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_MULHSU = CONTROL_WIDTH'(2);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_MULHU  = CONTROL_WIDTH'(3);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_DIV    = CONTROL_WIDTH'(4);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_DIVU   = CONTROL_WIDTH'(5);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_REM    = CONTROL_WIDTH'(6);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_REMU   = CONTROL_WIDTH'(7);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_MULW   = CONTROL_WIDTH'(8);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_DIVW   = CONTROL_WIDTH'(9);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_DIVUW  = CONTROL_WIDTH'(10);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_REMW   = CONTROL_WIDTH'(11);
  localparam logic [CONTROL_WIDTH-1:0] c_OP_REMUW  = CONTROL_WIDTH'(12);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [2*c_DW-1:0]   r_p;
  logic [c_DW-1:0]     r_m;
  logic [c_CW-1:0]     r_cnt;
  logic                r_is_w, r_is_div, r_is_rem, r_is_hi, r_neg;
  logic [c_DW-1:0]     r_result;

  logic                w_is_w, w_is_div, w_is_rem, w_is_hi, w_rsvd;
  logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [c_DW-1:0]     w_a_sx, w_b_sx, w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min;
  logic                w_div0, w_ovf, w_special;
  logic [c_DW-1:0]     w_special_res;
  logic [2*c_DW-1:0]   w_p_init, w_mul_next, w_div_next, w_full;
  logic [c_DW:0]       w_sum, w_rs, w_diff;
  logic                w_ge;
  logic [c_WW-1:0]     w_lo_w;
  logic [c_DW-1:0]     w_div_val, w_div_sv, w_fix_res;

  assign w_is_w   = i_op inside {c_OP_MULW, c_OP_DIVW, c_OP_DIVUW, c_OP_REMW, c_OP_REMUW};
  assign w_is_div = i_op inside {c_OP_DIV, c_OP_DIVU, c_OP_REM, c_OP_REMU,
                                 c_OP_DIVW, c_OP_DIVUW, c_OP_REMW, c_OP_REMUW};
  assign w_is_rem = i_op inside {c_OP_REM, c_OP_REMU, c_OP_REMW, c_OP_REMUW};
  assign w_is_hi  = i_op inside {c_OP_MULH, c_OP_MULHSU, c_OP_MULHU};
  assign w_rsvd   = i_op > c_OP_REMUW;
  assign w_a_signed = !(i_op inside {c_OP_MULHU, c_OP_DIVU, c_OP_REMU, c_OP_DIVUW, c_OP_REMUW});
  assign w_b_signed = w_a_signed && (i_op != c_OP_MULHSU);

  // *W ops see only the low word; sx is the architectural sign-extended view
  assign w_a_sx  = w_is_w ? {{(c_DW-c_WW){i_src_1[c_WW-1]}}, i_src_1[c_WW-1:0]} : i_src_1;
  assign w_b_sx  = w_is_w ? {{(c_DW-c_WW){i_src_2[c_WW-1]}}, i_src_2[c_WW-1:0]} : i_src_2;
  assign w_a_ext = (w_is_w && !w_a_signed) ? {{(c_DW-c_WW){1'b0}}, i_src_1[c_WW-1:0]} : w_a_sx;
  assign w_b_ext = (w_is_w && !w_b_signed) ? {{(c_DW-c_WW){1'b0}}, i_src_2[c_WW-1:0]} : w_b_sx;
  assign w_a_neg = w_a_signed & w_a_ext[c_DW-1];
  assign w_b_neg = w_b_signed & w_b_ext[c_DW-1];
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  assign w_min = w_is_w ? {{(c_DW-c_WW+1){1'b1}}, {(c_WW-1){1'b0}}}
                        : {1'b1, {(c_DW-1){1'b0}}};
  assign w_div0    = w_is_div && (w_b_ext == '0);
  assign w_ovf     = w_is_div && w_a_signed && (w_a_ext == w_min) && (w_b_ext == '1);
  assign w_special = w_rsvd || w_div0 || w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0)
      w_special_res = w_is_rem ? w_a_sx : '1;
    else if (w_ovf)
      w_special_res = w_is_rem ? '0 : w_a_sx;
  end

  // Divide keeps the dividend in the low half, shifting into the remainder above it
  always_comb begin
    w_p_init = {{c_DW{1'b0}}, w_b_mag};
    if (w_is_div)
      w_p_init = w_is_w ? {{c_DW{1'b0}}, w_a_mag[c_WW-1:0], {(c_DW-c_WW){1'b0}}}
                        : {{c_DW{1'b0}}, w_a_mag};
  end

  always_comb begin
    w_sum      = {1'b0, r_p[2*c_DW-1:c_DW]} + (r_p[0] ? {1'b0, r_m} : '0);
    w_mul_next = {w_sum, r_p[c_DW-1:1]};
    w_rs       = {r_p[2*c_DW-1:c_DW], r_p[c_DW-1]};
    w_diff     = w_rs - {1'b0, r_m};
    w_ge       = !w_diff[c_DW];
    w_div_next = {(w_ge ? w_diff[c_DW-1:0] : w_rs[c_DW-1:0]), r_p[c_DW-2:0], w_ge};
  end

  // After 32 multiply steps the word product sits in r_p[63:32]
  always_comb begin
    w_full    = r_neg ? -r_p : r_p;
    w_lo_w    = r_neg ? -r_p[c_DW-1:c_DW-c_WW] : r_p[c_DW-1:c_DW-c_WW];
    w_div_val = r_is_rem ? r_p[2*c_DW-1:c_DW] : r_p[c_DW-1:0];
    w_div_sv  = r_neg ? -w_div_val : w_div_val;
    if (r_is_div)
      w_fix_res = r_is_w ? {{(c_DW-c_WW){w_div_sv[c_WW-1]}}, w_div_sv[c_WW-1:0]} : w_div_sv;
    else if (r_is_w)
      w_fix_res = {{(c_DW-c_WW){w_lo_w[c_WW-1]}}, w_lo_w};
    else
      w_fix_res = r_is_hi ? w_full[2*c_DW-1:c_DW] : w_full[c_DW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_is_w   <= 1'b0;
      r_is_div <= 1'b0;
      r_is_rem <= 1'b0;
      r_is_hi  <= 1'b0;
      r_neg    <= 1'b0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_is_w   <= w_is_w;
            r_is_div <= w_is_div;
            r_is_rem <= w_is_rem;
            r_is_hi  <= w_is_hi;
            r_neg    <= w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_m      <= w_is_div ? w_b_mag : w_a_mag;
            r_p      <= w_p_init;
            r_cnt    <= w_is_w ? c_CW'(c_WW-1) : c_CW'(c_DW-1);
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_p <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == '0)
            r_state <= S_FIX;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == S_IDLE) && !i_rst;
  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Directed and random self-checking bench for mul_div_unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic [3:0]  i_op = 4'd0;
  logic [63:0] i_src_1 = 64'd0;
  logic [63:0] i_src_2 = 64'd0;
  logic        o_ready, o_busy, o_done;
  logic [63:0] o_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.DATA_WIDTH(64), .WORD_WIDTH(32), .CONTROL_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush), .i_op(i_op), .i_src_1(i_src_1), .i_src_2(i_src_2),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural result computed with plain arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    longint sa64, sb64;
    int sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    logic [63:0] r;
    logic ovf64, ovf32;
    sa = $signed(a); sb = $signed(b);
    ua = {64'd0, a}; ub = {64'd0, b};
    sa64 = a; sb64 = b;
    sa32 = a[31:0]; sb32 = b[31:0];
    ua32 = a[31:0]; ub32 = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
    r = 64'd0; r32 = 32'd0;
    case (op)
      4'd0: begin p = sa * sb; r = p[63:0]; end
      4'd1: begin p = sa * sb; r = p[127:64]; end
      4'd2: begin p = sa * ub; r = p[127:64]; end
      4'd3: begin p = ua * ub; r = p[127:64]; end
      4'd4: if (b == 0) r = '1; else if (ovf64) r = a; else r = sa64 / sb64;
      4'd5: if (b == 0) r = '1; else r = a / b;
      4'd6: if (b == 0) r = a; else if (ovf64) r = 0; else r = sa64 % sb64;
      4'd7: if (b == 0) r = a; else r = a % b;
      4'd8: r32 = ua32 * ub32;
      4'd9: if (ub32 == 0) r32 = '1; else if (ovf32) r32 = ua32; else r32 = sa32 / sb32;
      4'd10: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
      4'd11: if (ub32 == 0) r32 = ua32; else if (ovf32) r32 = 0; else r32 = sa32 % sb32;
      4'd12: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
      default: r = 64'd0;
    endcase
    if (op >= 4'd8 && op <= 4'd12) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic is_w, is_div, is_sdiv, zero, ovf;
    is_w    = (op >= 4'd8);
    is_div  = (op >= 4'd4 && op <= 4'd7) || (op >= 4'd9 && op <= 4'd12);
    is_sdiv = (op == 4'd4) || (op == 4'd6) || (op == 4'd9) || (op == 4'd11);
    zero    = is_w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf     = is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                   : (a == 64'h8000_0000_0000_0000 && b == '1);
    if (op > 4'd12) return 1;
    if (is_div && zero) return 1;
    if (is_sdiv && ovf) return 1;
    return is_w ? 34 : 66;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input string tag);
    int cyc;
    int lat;
    lat = exp_lat(op, a, b);
    @(negedge clk);
    cyc = 0;
    while (o_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b1; i_op = op; i_src_1 = a; i_src_2 = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_op    = 4'($urandom);
    i_src_1 = {$urandom, $urandom};
    i_src_2 = {$urandom, $urandom};
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (o_done !== 1'b1 && cyc < 100);
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " result"}, o_result, exp_res);
    chk({tag, " ready in done"}, 64'(o_ready), 64'd0);
    @(negedge clk);
    chk({tag, " ready after"}, 64'(o_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    int          seen;

    repeat (3) @(negedge clk);
    chk("reset ready", 64'(o_ready), 64'd0);
    chk("reset busy", 64'(o_busy), 64'd0);
    chk("reset done", 64'(o_done), 64'd0);
    chk("reset result", o_result, 64'd0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("ready out of reset", 64'(o_ready), 64'd1);

    run_op(4'd0,  64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, "mul");
    run_op(4'd3,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu");
    run_op(4'd4,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div");
    run_op(4'd6,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "rem");
    run_op(4'd7,  64'd7, 64'd2, 64'd1, "remu");
    run_op(4'd5,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu by0");
    run_op(4'd6,  64'd5, 64'd0, 64'd5, "rem by0");
    run_op(4'd4,  64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, "div ovf");
    run_op(4'd6,  64'h8000_0000_0000_0000, '1, 64'd0, "rem ovf");
    run_op(4'd15, 64'd123, 64'd456, 64'd0, "reserved");
    run_op(4'd10, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "divuw");
    run_op(4'd8,  64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw");

    // Flush a DIV in flight: previous result must survive
    @(negedge clk);
    i_valid = 1'b1; i_op = 4'd4; i_src_1 = -64'sd7; i_src_2 = 64'd2;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy before flush", 64'(o_busy), 64'd1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush busy", 64'(o_busy), 64'd0);
    chk("flush ready", 64'(o_ready), 64'd1);
    chk("flush result", o_result, 64'hFFFF_FFFF_FFFF_FFFE);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (o_done === 1'b1) seen++;
    end
    chk("flush no done", 64'(seen), 64'd0);

    // Valid together with flush in IDLE must not start an op
    i_valid = 1'b1; i_flush = 1'b1; i_op = 4'd5; i_src_1 = 64'd9; i_src_2 = 64'd0;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    chk("valid+flush busy", 64'(o_busy), 64'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done === 1'b1) seen++;
    end
    chk("valid+flush no done", 64'(seen), 64'd0);
    chk("valid+flush result", o_result, 64'hFFFF_FFFF_FFFF_FFFE);

    // Reset in the middle of a MUL
    i_valid = 1'b1; i_op = 4'd0; i_src_1 = 64'd3; i_src_2 = 64'd5;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (20) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 64'(o_busy), 64'd0);
    chk("midrst done", 64'(o_done), 64'd0);
    chk("midrst ready", 64'(o_ready), 64'd0);
    chk("midrst result", o_result, 64'd0);
    i_rst = 1'b0;
    run_op(4'd0, 64'd3, 64'd5, 64'd15, "mul after reset");

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = $urandom_range(0, 1) ? 64'd0 : {$urandom, 32'd0};
        1: begin
          b = '1;
          a = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : {$urandom, 32'h8000_0000};
        end
        2: b = 64'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(op, a, b, ref_result(op, a, b), $sformatf("rand%0d op%0d", n, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
